result_buffer: RTL and testbench

- Downstream stage of the add/sub operation state machine.
- Captures each single-cycle result strobe (out_valid/out_res) into a small FIFO so a slower consumer can pop results at its own pace.
- Keeps a saturating running sum of accepted results and a saturating count of results dropped on overflow.
- Purely synchronous; no combinational path from in_valid to any output.

---
 rtl/result_buffer.sv | 133 +++++++++++++
 tb/tb_result_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_buffer.sv
// ---------------------------------------------------------------------------
// result_buffer
//
// Purpose:
//   Downstream stage of the add/sub operation state machine. Every cycle that
//   in_valid is high counts as one distinct result. That result is written
//   into a small FIFO, so a slower consumer can pop results whenever it is
//   ready.
//   Alongside the FIFO the block keeps two saturating counters:
//     - a running sum of all accepted results, with a sticky overflow flag;
//     - a count of results that were dropped because the FIFO was full.
//   All outputs are registered or decoded from registers. No combinational
//   path runs from in_valid to any output.
//
// Ports:
//   clk       in   system clock; all state changes on the rising edge
//   reset     in   synchronous, active-high; clears all state
//   in_valid  in   result strobe from the upstream out_valid
//   in_res    in   result value from the upstream out_res (DATA_W bits)
//   rd_en     in   consumer pop request
//   rd_data   out  last popped value; registered, holds between pops
//   rd_valid  out  one-cycle pulse: rd_data was popped on the last edge
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  current occupancy ($clog2(DEPTH)+1 bits)
//   acc_sum   out  saturating sum of accepted results (ACC_W bits)
//   acc_ovf   out  sticky; set when the unclamped sum exceeded the maximum
//   drop_cnt  out  saturating (at 255) count of rejected writes
// ---------------------------------------------------------------------------
module result_buffer #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,   // power of two, at least 2
   parameter int ACC_W  = 8    // must exceed DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_res,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [ACC_W-1:0]         acc_sum,
   output logic                     acc_ovf,
   output logic [7:0]               drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic              wr_ok;
   logic              rd_ok;
   logic              drop;
   logic [ACC_W:0]    sum_ext;   // one extra bit catches the carry out

   // Status flags come straight from the registered count.
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // When the FIFO is full, a write is still accepted if a pop happens in the
   // same cycle, because the pop frees a slot. The empty check in rd_ok means
   // a write never bypasses straight to the reader.
   assign wr_ok = in_valid && (!full || rd_en);
   assign rd_ok = rd_en && !empty;
   assign drop  = in_valid && full && !rd_en;

   assign sum_ext = {1'b0, acc_sum} + (ACC_W+1)'(in_res);

   // NOTE: The storage array has no reset. After a reset, occupancy and the
   // pointers are zero, so any stale entry can never be read. Leaving the
   // array unreset lets it map onto plain RAM or flops without a reset net.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= in_res;
      end
   end

   // NOTE: Every register in this block is assigned with <=. Each statement
   // then sees the values from before the edge. That matters for a full FIFO
   // with a pop and a write in the same cycle: wr_ptr == rd_ptr, and the read
   // must return the old entry, not the new value going into that same slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         acc_sum  <= '0;
         acc_ovf  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         rd_valid <= rd_ok;

         // DEPTH is a power of two, so the pointers wrap on their own.
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         if (rd_ok) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end

         // A write and a read in the same cycle leave the count unchanged.
         if (wr_ok && !rd_ok) begin
            count <= count + 1'b1;
         end else if (!wr_ok && rd_ok) begin
            count <= count - 1'b1;
         end

         if (wr_ok) begin
            if (sum_ext[ACC_W]) begin
               acc_sum <= '1;
               acc_ovf <= 1'b1;
            end else begin
               acc_sum <= sum_ext[ACC_W-1:0];
            end
         end

         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_result_buffer
//
// Purpose:
//   Directed, self-checking bench for result_buffer with the default
//   parameters (DATA_W=4, DEPTH=4, ACC_W=8). Expected values are worked out
//   by hand from the intended behaviour.
//   Inputs change 1 ns after a rising edge and outputs are sampled at that
//   same point, so nothing is sampled on the active edge.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_result_buffer;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [3:0] in_res;
   logic       rd_en;
   logic [3:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic [2:0] count;
   logic [7:0] acc_sum;
   logic       acc_ovf;
   logic [7:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   result_buffer #(.DATA_W(4), .DEPTH(4), .ACC_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_res   (in_res),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .acc_sum  (acc_sum),
      .acc_ovf  (acc_ovf),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge. Inputs may change and outputs are sampled afterwards.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] v);
      in_valid = 1'b1;
      in_res   = v;
      rd_en    = 1'b0;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      rd_en    = 1'b0;
      tick();
      reset    = 1'b0;
   endtask

   // Holds rd_en for one cycle per expected value and checks each pop.
   task automatic drain(input string tag, input logic [3:0] exp_q [4], input int n);
      rd_en    = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         check($sformatf("%s_vld%0d", tag, i), rd_valid, 1);
         check($sformatf("%s_dat%0d", tag, i), rd_data, exp_q[i]);
      end
      rd_en = 1'b0;
   endtask

   logic [3:0] fill_vals [4] = '{4'd8, 4'd7, 4'd0, 4'd15};
   logic [3:0] pass_vals [4] = '{4'd7, 4'd0, 4'd15, 4'd3};

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_res   = '0;
      rd_en    = 1'b0;

      // Reset held for 2 cycles, then released.
      tick();
      tick();
      reset = 1'b0;
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_acc_sum", acc_sum, 0);
      check("rst_acc_ovf", acc_ovf, 0);
      check("rst_drop_cnt", drop_cnt, 0);

      // Fill the FIFO, then try to push while full (the push is dropped).
      for (int i = 0; i < 4; i++) push(fill_vals[i]);
      check("fill_count", count, 4);
      check("fill_full", full, 1);
      check("fill_acc", acc_sum, 30);
      push(4'd3);
      check("drop_cnt", drop_cnt, 1);
      check("drop_count", count, 4);
      check("drop_acc", acc_sum, 30);
      drain("drain1", fill_vals, 4);
      check("drain1_empty", empty, 1);
      check("drain1_count", count, 0);
      tick();
      check("idle_rd_valid", rd_valid, 0);
      check("idle_rd_data_hold", rd_data, 15);

      // Full FIFO with a push and a pop in the same cycle.
      do_reset();
      for (int i = 0; i < 4; i++) push(fill_vals[i]);
      in_valid = 1'b1;
      in_res   = 4'd3;
      rd_en    = 1'b1;
      tick();
      in_valid = 1'b0;
      rd_en    = 1'b0;
      check("pass_rd_valid", rd_valid, 1);
      check("pass_rd_data", rd_data, 8);
      check("pass_count", count, 4);
      check("pass_acc", acc_sum, 33);
      check("pass_drop", drop_cnt, 0);
      drain("drain2", pass_vals, 4);
      check("drain2_empty", empty, 1);

      // Pop request while empty: nothing happens and rd_data holds.
      rd_en = 1'b1;
      tick();
      check("mt_rd_valid", rd_valid, 0);
      check("mt_rd_data", rd_data, 3);
      check("mt_count", count, 0);
      // Push and pop together while empty: only the write is accepted.
      in_valid = 1'b1;
      in_res   = 4'd5;
      tick();
      in_valid = 1'b0;
      check("mtwr_count", count, 1);
      check("mtwr_rd_valid", rd_valid, 0);
      check("mtwr_rd_data", rd_data, 3);
      tick();
      rd_en = 1'b0;
      check("mtwr_pop_valid", rd_valid, 1);
      check("mtwr_pop_data", rd_data, 5);
      check("mtwr_empty", empty, 1);

      // Saturation: 17 x 15 = 255 exactly, so acc_ovf stays clear.
      do_reset();
      in_valid = 1'b1;
      in_res   = 4'd15;
      rd_en    = 1'b1;
      for (int i = 0; i < 17; i++) tick();
      check("sat_acc", acc_sum, 255);
      check("sat_ovf", acc_ovf, 0);
      check("sat_count", count, 1);
      in_res = 4'd1;
      tick();
      check("ovf_acc", acc_sum, 255);
      check("ovf_flag", acc_ovf, 1);
      in_valid = 1'b0;
      rd_en    = 1'b0;
      for (int i = 0; i < 3; i++) push(4'd2);
      check("sat_full", full, 1);
      check("ovf_sticky", acc_ovf, 1);

      // drop_cnt saturates at 255.
      in_valid = 1'b1;
      in_res   = 4'd2;
      for (int i = 0; i < 260; i++) tick();
      in_valid = 1'b0;
      check("drop_sat", drop_cnt, 255);
      check("drop_sat_count", count, 4);

      // Pop down to two entries, then reset with every other input active.
      rd_en = 1'b1;
      tick();
      tick();
      rd_en = 1'b0;
      check("pre_rst_count", count, 2);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_res   = 4'd9;
      rd_en    = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      rd_en    = 1'b0;
      check("mid_rst_count", count, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_acc", acc_sum, 0);
      check("mid_rst_ovf", acc_ovf, 0);
      check("mid_rst_drop", drop_cnt, 0);
      check("mid_rst_rd_valid", rd_valid, 0);
      check("mid_rst_rd_data", rd_data, 0);

      // Stale entries must not reappear after the reset.
      push(4'd6);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("post_rst_data", rd_data, 6);
      check("post_rst_empty", empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
